// File: rtl/pipeline_hazard_controller.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline.
// Tracks destination registers in a shadow scoreboard to drive stalls, flushes and forwarding selects.
module pipeline_hazard_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ifid_rs_i,
  input  logic [4:0]           ifid_rt_i,
  input  logic                 ifid_uses_rs_i,
  input  logic                 ifid_uses_rt_i,
  input  logic                 id_reg_write_i,
  input  logic                 id_mem_read_i,
  input  logic [4:0]           id_write_reg_i,
  input  logic                 ex_jump_i,
  input  logic                 mem_branch_taken_i,
  output logic                 pc_enable_o,
  output logic                 ifid_enable_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic                 exmem_flush_o,
  output logic [1:0]           fwd_a_o,
  output logic [1:0]           fwd_b_o,
  output logic                 fwd_id_a_o,
  output logic                 fwd_id_b_o,
  output logic [CNT_WIDTH-1:0] stall_count_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  logic       ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0] ex_dest, ex_rs, ex_rt;
  logic       mem_valid, mem_reg_write, mem_mem_read;
  logic [4:0] mem_dest;
  logic       wb_valid, wb_reg_write;
  logic [4:0] wb_dest;

  logic load_use;
  logic redirect;
  logic stall;
  logic ex_bubble;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [1:0] ex_select(
    input logic [4:0] src,
    input logic       m_valid, m_reg_write, m_mem_read,
    input logic [4:0] m_dest,
    input logic       w_valid, w_reg_write,
    input logic [4:0] w_dest
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (m_valid && m_reg_write && !m_mem_read && m_dest != 5'd0 && m_dest == src)
      sel = 2'd2;
    else if (w_valid && w_reg_write && w_dest != 5'd0 && w_dest == src)
      sel = 2'd1;
    return sel;
  endfunction

  // A redirect squashes the stalled instruction anyway, so it overrides the stall.
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
               ((ifid_uses_rs_i && ifid_rs_i == ex_dest) ||
                (ifid_uses_rt_i && ifid_rt_i == ex_dest));
    redirect  = ex_jump_i || mem_branch_taken_i;
    stall     = load_use && !redirect;
    ex_bubble = stall || redirect;
  end

  always_comb begin
    pc_enable_o   = !stall;
    ifid_enable_o = !stall;
    ifid_flush_o  = redirect && reset;
    idex_flush_o  = redirect && reset;
    exmem_flush_o = mem_branch_taken_i && reset;
  end

  always_comb begin
    fwd_a_o = ex_select(ex_rs, mem_valid, mem_reg_write, mem_mem_read, mem_dest,
                        wb_valid, wb_reg_write, wb_dest);
    fwd_b_o = ex_select(ex_rt, mem_valid, mem_reg_write, mem_mem_read, mem_dest,
                        wb_valid, wb_reg_write, wb_dest);
    fwd_id_a_o = wb_valid && wb_reg_write && (wb_dest != 5'd0) && (wb_dest == ifid_rs_i);
    fwd_id_b_o = wb_valid && wb_reg_write && (wb_dest != 5'd0) && (wb_dest == ifid_rt_i);
  end

  // Bubbles are fully zeroed so a dead EX slot never selects a forwarding path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_dest       <= 5'd0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
    end else if (ex_bubble) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_dest       <= 5'd0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
    end else begin
      ex_valid      <= 1'b1;
      ex_reg_write  <= id_reg_write_i;
      ex_mem_read   <= id_mem_read_i;
      ex_dest       <= id_write_reg_i;
      ex_rs         <= ifid_rs_i;
      ex_rt         <= ifid_rt_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_dest      <= 5'd0;
    end else if (mem_branch_taken_i) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_dest      <= 5'd0;
    end else begin
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      mem_dest      <= ex_dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest      <= 5'd0;
    end else begin
      wb_valid     <= mem_valid;
      wb_reg_write <= mem_reg_write;
      wb_dest      <= mem_dest;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_o <= '0;
      flush_count_o <= '0;
    end else begin
      if (stall && stall_count_o != CNT_MAX)
        stall_count_o <= stall_count_o + 1'b1;
      if (redirect && flush_count_o != CNT_MAX)
        flush_count_o <= flush_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed hazard scenarios then random traffic,
// compared against an instruction-history model of the pipeline.
module tb_pipeline_hazard_controller;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ifid_rs_i, ifid_rt_i, id_write_reg_i;
  logic          ifid_uses_rs_i, ifid_uses_rt_i, id_reg_write_i, id_mem_read_i;
  logic          ex_jump_i, mem_branch_taken_i;
  logic          pc_enable_o, ifid_enable_o, ifid_flush_o, idex_flush_o, exmem_flush_o;
  logic [1:0]    fwd_a_o, fwd_b_o;
  logic          fwd_id_a_o, fwd_id_b_o;
  logic [CW-1:0] stall_count_o, flush_count_o;

  pipeline_hazard_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .ifid_uses_rs_i(ifid_uses_rs_i), .ifid_uses_rt_i(ifid_uses_rt_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .id_write_reg_i(id_write_reg_i),
    .ex_jump_i(ex_jump_i), .mem_branch_taken_i(mem_branch_taken_i),
    .pc_enable_o(pc_enable_o), .ifid_enable_o(ifid_enable_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .fwd_id_a_o(fwd_id_a_o), .fwd_id_b_o(fwd_id_b_o),
    .stall_count_o(stall_count_o), .flush_count_o(flush_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       rw;
    bit       mr;
    bit [4:0] d;
    bit [4:0] rs;
    bit [4:0] rt;
  } ins_t;

  // Youngest in-flight instruction first: age 0 = EX, 1 = MEM, 2 = WB.
  ins_t q[$];
  int   m_stalls, m_flushes;
  int   total, bad;

  function automatic ins_t at(input int age);
    ins_t e;
    e = '{default: 0};
    if (age < q.size()) e = q[age];
    return e;
  endfunction

  function automatic bit [1:0] fwd_ex(input bit [4:0] src);
    ins_t m, w;
    m = at(1);
    w = at(2);
    if (m.v && m.rw && !m.mr && m.d != 0 && m.d == src) return 2'd2;
    if (w.v && w.rw && w.d != 0 && w.d == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit fwd_id(input bit [4:0] src);
    ins_t w;
    w = at(2);
    return w.v && w.rw && w.d != 0 && w.d == src;
  endfunction

  function automatic bit load_use(input bit [4:0] rs, rt, input bit urs, urt);
    ins_t e;
    e = at(0);
    return e.v && e.mr && e.d != 0 && ((urs && rs == e.d) || (urt && rt == e.d));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input bit [4:0] rs, rt, input bit urs, urt, rw, mr,
                            input bit [4:0] wr, input bit jmp, br);
    ifid_rs_i = rs; ifid_rt_i = rt; ifid_uses_rs_i = urs; ifid_uses_rt_i = urt;
    id_reg_write_i = rw; id_mem_read_i = mr; id_write_reg_i = wr;
    ex_jump_i = jmp; mem_branch_taken_i = br;
  endtask

  // Called at a falling edge: drive, check against the model, clock, advance the model.
  task automatic cycle(input bit [4:0] rs, rt, input bit urs, urt, rw, mr,
                       input bit [4:0] wr, input bit jmp, br);
    bit   redir, st;
    ins_t e, nw;
    set_inputs(rs, rt, urs, urt, rw, mr, wr, jmp, br);
    #1;
    redir = jmp || br;
    st    = load_use(rs, rt, urs, urt) && !redir;
    e     = at(0);
    check("pc_enable", 32'(pc_enable_o), 32'(!st));
    check("ifid_enable", 32'(ifid_enable_o), 32'(!st));
    check("ifid_flush", 32'(ifid_flush_o), 32'(redir));
    check("idex_flush", 32'(idex_flush_o), 32'(redir));
    check("exmem_flush", 32'(exmem_flush_o), 32'(br));
    check("fwd_a", 32'(fwd_a_o), 32'(fwd_ex(e.rs)));
    check("fwd_b", 32'(fwd_b_o), 32'(fwd_ex(e.rt)));
    check("fwd_id_a", 32'(fwd_id_a_o), 32'(fwd_id(rs)));
    check("fwd_id_b", 32'(fwd_id_b_o), 32'(fwd_id(rt)));
    check("stall_count", 32'(stall_count_o), 32'(m_stalls));
    check("flush_count", 32'(flush_count_o), 32'(m_flushes));
    @(posedge clk);
    if (br && q.size() > 0) q[0] = '{default: 0};
    nw = '{default: 0};
    if (!st && !redir) nw = '{v: 1'b1, rw: rw, mr: mr, d: wr, rs: rs, rt: rt};
    q.push_front(nw);
    if (q.size() > 3) void'(q.pop_back());
    if (st && m_stalls < CMAX) m_stalls++;
    if (redir && m_flushes < CMAX) m_flushes++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    reset = 1'b0;
    set_inputs(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("reset_pc_enable", 32'(pc_enable_o), 32'd1);
    check("reset_fwd_a", 32'(fwd_a_o), 32'd0);
    check("reset_stall_count", 32'(stall_count_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // lw $8 then a reader of $8: one stall, then forward from WB.
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    cycle(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
    cycle(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
    #1;
    check("dir_loaduse_fwd_a_wb", 32'(fwd_a_o), 32'd1);
    check("dir_loaduse_stalls", 32'(stall_count_o), 32'd1);

    // add $9 then sub $9,$9 forwards from EX/MEM, next reader from MEM/WB.
    cycle(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0);
    cycle(5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 1'b0, 1'b0);
    #1;
    check("dir_fwd_a_mem", 32'(fwd_a_o), 32'd2);
    check("dir_fwd_b_mem", 32'(fwd_b_o), 32'd2);
    cycle(5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("dir_fwd_a_wb", 32'(fwd_a_o), 32'd1);

    // Same dest in MEM and WB: EX/MEM wins. Dest 0 never forwards.
    cycle(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0, 1'b0);
    cycle(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 1'b0, 1'b0);
    cycle(5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("dir_fwd_priority", 32'(fwd_a_o), 32'd2);
    cycle(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    check("dir_fwd_r0", 32'(fwd_a_o), 32'd0);

    // Branch and jump together with a load-use match: flush wins, no stall counted.
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
    cycle(5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    #1;
    check("dir_flush_stalls", 32'(stall_count_o), 32'd1);
    check("dir_flush_count", 32'(flush_count_o), 32'd1);

    // Back-to-back loads feeding themselves saturate the stall counter.
    for (int i = 0; i < 40; i++)
      cycle(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    check("dir_stall_saturate", 32'(stall_count_o), 32'(CMAX));

    // Reset in the middle of a stall drops everything in flight.
    cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    set_inputs(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
    #1;
    check("mid_stall_seen", 32'(pc_enable_o), 32'd0);
    mem_branch_taken_i = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_reset_pc_enable", 32'(pc_enable_o), 32'd1);
    check("mid_reset_ifid_enable", 32'(ifid_enable_o), 32'd1);
    check("mid_reset_ifid_flush", 32'(ifid_flush_o), 32'd0);
    check("mid_reset_exmem_flush", 32'(exmem_flush_o), 32'd0);
    check("mid_reset_fwd_b", 32'(fwd_b_o), 32'd0);
    check("mid_reset_stall_count", 32'(stall_count_o), 32'd0);
    check("mid_reset_flush_count", 32'(flush_count_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b1;
    cycle(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0);
    cycle(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 300; i++)
      cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
